// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg
// Shared definitions for the SNN per-image phase sequencer: the FSM state
// encoding, the default threshold width, the threshold floor and the phase
// lengths, plus a helper that sizes the phase counters.
package snn_ctrl_pkg;

  // One image walks MAX -> LOAD -> RUN -> GAP; DONE closes a batch and
  // ERR parks the sequencer after a maxer watchdog timeout.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAX  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } phase_state_t;

  localparam int W_DEF       = 24;    // threshold width, Q12 fixed point
  localparam int TH_MIN_DEF  = 4096;  // 1.0 in Q12, floor for a zero threshold
  localparam int T_RUN_DEF   = 350;   // RUN length, one IPS step per cycle
  localparam int T_GAP_DEF   = 16;    // settle cycles between images
  localparam int NUM_IMG_DEF = 8;     // images per batch
  localparam int MAX_TO_DEF  = 256;   // maxer watchdog limit in cycles

  // Bits needed to hold n-1; never less than one, so a phase of length 1
  // still gets a real counter.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snn_phase_seq_if.sv
// snn_phase_seq_if
// Bundle between the phase sequencer and the maxer.
//   maxing      : sequencer -> maxer, enables the maxer sweep
//   maxer_valid : maxer -> sequencer, result strobe
//   threshold   : maxer -> sequencer, W-bit Q12 result
//   mx_start    : maxer -> sequencer, maxer's start_ips_gen
//   mx_next     : maxer -> sequencer, maxer's next_ips_gen
// master = sequencer side, slave = maxer side.
interface snn_phase_seq_if #(
  parameter int W = snn_ctrl_pkg::W_DEF
);
  logic         maxing;
  logic         maxer_valid;
  logic [W-1:0] threshold;
  logic         mx_start;
  logic         mx_next;

  modport master (
    output maxing,
    input  maxer_valid, threshold, mx_start, mx_next
  );

  modport slave (
    input  maxing,
    output maxer_valid, threshold, mx_start, mx_next
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer
// Loadable down-counter used to time one phase. Loading takes priority over
// counting; the count saturates at zero and expired is high while it is zero.
//   clk, rst : clock, synchronous active-high reset (count cleared)
//   load     : load load_val on the next edge
//   load_val : initial count, phase length minus one
//   expired  : count has reached zero
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: reload when a phase starts, otherwise count down and stop
  // at zero so a stale timer never wraps into a bogus expiry later.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/snn_phase_seq.sv
// snn_phase_seq
// Per-image phase sequencer for the SNN core. Steps a batch of NUM_IMG images
// through MAX (maxer sweep), LOAD (threshold into the neurons), RUN (IPS
// generator window of T_RUN steps) and GAP (T_GAP settle cycles).
//   clk, rst         : clock, synchronous active-high reset
//   go, halt         : host start (IDLE only) and abort request
//   mx               : maxer bundle (maxing out; valid/threshold/start/next in)
//   ips_start/next   : IPS generator controls; maxer pass-through during MAX
//   th_out, th_load  : held threshold and its one-cycle load strobe
//   run_en           : neuron array enable
//   img_idx          : current image index
//   busy, done, err  : not idle, end-of-batch pulse, sticky watchdog error
module snn_phase_seq import snn_ctrl_pkg::*; #(
  parameter int W       = W_DEF,
  parameter int T_RUN   = T_RUN_DEF,
  parameter int T_GAP   = T_GAP_DEF,
  parameter int NUM_IMG = NUM_IMG_DEF,
  parameter int MAX_TO  = MAX_TO_DEF,
  parameter int TH_MIN  = TH_MIN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            halt,
  snn_phase_seq_if.master mx,
  output logic            ips_start,
  output logic            ips_next,
  output logic [W-1:0]    th_out,
  output logic            th_load,
  output logic            run_en,
  output logic [7:0]      img_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int WD_W  = cnt_w(MAX_TO);
  localparam int RUN_W = cnt_w(T_RUN);
  localparam int GAP_W = cnt_w(T_GAP);

  localparam logic [WD_W-1:0]  WD_INIT  = WD_W'(MAX_TO - 1);
  localparam logic [RUN_W-1:0] RUN_INIT = RUN_W'(T_RUN - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(T_GAP - 1);
  localparam logic [W-1:0]     TH_MIN_V = W'(TH_MIN);
  localparam logic [7:0]       LAST_IMG = 8'(NUM_IMG - 1);

  phase_state_t state_q, state_d;
  logic         maxing_q, maxing_d;
  logic         ips_start_q, ips_start_d;
  logic         ips_next_q, ips_next_d;
  logic [W-1:0] th_out_q, th_out_d;
  logic         th_load_q, th_load_d;
  logic         run_en_q, run_en_d;
  logic [7:0]   img_idx_q, img_idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         halt_pend_q, halt_pend_d;

  logic wd_load, run_load, gap_load;
  logic wd_expired, run_expired, gap_expired;

  phase_timer #(.WIDTH(WD_W)) u_wd_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WD_INIT),
    .expired  (wd_expired)
  );

  phase_timer #(.WIDTH(RUN_W)) u_run_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .load_val (RUN_INIT),
    .expired  (run_expired)
  );

  phase_timer #(.WIDTH(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_INIT),
    .expired  (gap_expired)
  );

  // Next-state logic. Each timer is loaded on the edge that enters its
  // phase, so it reads zero in the phase's last cycle. A halt in MAX cannot
  // stop the maxer mid-sweep (it has no clear), so it is remembered and
  // honoured once the maxer reports. The outputs are derived from the next
  // state so they are registered yet line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    th_out_d    = th_out_q;
    img_idx_d   = img_idx_q;
    halt_pend_d = halt_pend_q;
    wd_load     = 1'b0;
    run_load    = 1'b0;
    gap_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go && !halt) begin
          state_d     = ST_MAX;
          img_idx_d   = '0;
          wd_load     = 1'b1;
          halt_pend_d = 1'b0;
        end
      end
      ST_MAX: begin
        if (mx.maxer_valid) begin
          halt_pend_d = 1'b0;
          if (halt || halt_pend_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_LOAD;
            th_out_d = (mx.threshold == '0) ? TH_MIN_V : mx.threshold;
          end
        end else if (wd_expired) begin
          state_d     = ST_ERR;
          halt_pend_d = 1'b0;
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d  = ST_RUN;
        run_load = 1'b1;
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (run_expired) begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (gap_expired) begin
          if (img_idx_q == LAST_IMG) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_MAX;
            img_idx_d = img_idx_q + 8'd1;
            wd_load   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    maxing_d    = (state_d == ST_MAX);
    th_load_d   = (state_d == ST_LOAD);
    run_en_d    = (state_d == ST_RUN);
    ips_next_d  = (state_d == ST_RUN);
    ips_start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      maxing_q    <= 1'b0;
      ips_start_q <= 1'b0;
      ips_next_q  <= 1'b0;
      th_out_q    <= '0;
      th_load_q   <= 1'b0;
      run_en_q    <= 1'b0;
      img_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      maxing_q    <= maxing_d;
      ips_start_q <= ips_start_d;
      ips_next_q  <= ips_next_d;
      th_out_q    <= th_out_d;
      th_load_q   <= th_load_d;
      run_en_q    <= run_en_d;
      img_idx_q   <= img_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // During MAX the maxer owns the IPS generator; passing its strobes through
  // combinationally keeps them aligned with the maxer's own pipeline.
  assign ips_start = (state_q == ST_MAX) ? mx.mx_start : ips_start_q;
  assign ips_next  = (state_q == ST_MAX) ? mx.mx_next  : ips_next_q;

  assign mx.maxing = maxing_q;
  assign th_out    = th_out_q;
  assign th_load   = th_load_q;
  assign run_en    = run_en_q;
  assign img_idx   = img_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_snn_phase_seq.sv
// tb_snn_phase_seq
// Self-checking bench for snn_phase_seq with a two-image batch. A small maxer
// model answers each sweep after a chosen latency; every batch is compared
// against expectations computed from the phase lengths with plain arithmetic.
module tb_snn_phase_seq;

  localparam int W       = 24;
  localparam int T_RUN   = 350;
  localparam int T_GAP   = 16;
  localparam int NUM_IMG = 2;
  localparam int MAX_TO  = 256;
  localparam int TH_MIN  = 4096;

  localparam int H_NONE = 0;
  localparam int H_MAX  = 1;
  localparam int H_RUN  = 2;
  localparam int H_GAP  = 3;

  typedef struct packed {
    int busy;
    int maxing;
    int loads;
    int run;
    int starts;
    int done;
    int started;
  } batch_exp_t;

  logic         clk = 1'b0;
  logic         rst, go, halt;
  logic         ips_start, ips_next, th_load, run_en, busy, done, err;
  logic [W-1:0] th_out;
  logic [7:0]   img_idx;

  int err_count   = 0;
  int check_count = 0;

  int           lat_tab [NUM_IMG];
  logic [W-1:0] thr_tab [NUM_IMG];
  int           halt_phase;
  int           halt_at;
  bit           noise;
  logic [31:0]  th_model;

  snn_phase_seq_if #(.W(W)) mx_if ();

  snn_phase_seq #(
    .W       (W),
    .T_RUN   (T_RUN),
    .T_GAP   (T_GAP),
    .NUM_IMG (NUM_IMG),
    .MAX_TO  (MAX_TO),
    .TH_MIN  (TH_MIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .halt      (halt),
    .mx        (mx_if),
    .ips_start (ips_start),
    .ips_next  (ips_next),
    .th_out    (th_out),
    .th_load   (th_load),
    .run_en    (run_en),
    .img_idx   (img_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports the ones that disagree.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // A zero threshold is floored to 1.0 in Q12.
  function automatic logic [31:0] thExp(input logic [W-1:0] t);
    return (t == '0) ? 32'(TH_MIN) : 32'(t);
  endfunction

  // Expected batch totals: each image costs (latency+1) MAX cycles, one LOAD,
  // T_RUN RUN cycles and T_GAP GAP cycles; a halt cuts the first image short
  // and a full batch ends with a single DONE cycle.
  function automatic batch_exp_t refModel();
    batch_exp_t e;
    e = '0;
    for (int i = 0; i < NUM_IMG; i++) begin
      e.started++;
      e.maxing += lat_tab[i] + 1;
      e.busy   += lat_tab[i] + 1;
      if (halt_phase == H_MAX) return e;
      e.loads++;
      e.busy++;
      e.starts++;
      if (halt_phase == H_RUN) begin
        e.run  += halt_at + 1;
        e.busy += halt_at + 1;
        return e;
      end
      e.run  += T_RUN;
      e.busy += T_RUN;
      if (halt_phase == H_GAP) begin
        e.busy += halt_at + 1;
        return e;
      end
      e.busy += T_GAP;
    end
    e.busy++;
    e.done = 1;
    return e;
  endfunction

  // Runs one batch from a go pulse to the return to IDLE, playing the maxer,
  // injecting halts and noise, and checks the observed totals afterwards.
  task automatic applyStimulus(input string name);
    batch_exp_t e;
    int busy_n = 0, maxing_n = 0, loads_n = 0, run_n = 0, inext_n = 0;
    int istart_n = 0, done_n = 0, rises = 0;
    int mx_cnt = 0, img_seen = -1, run_step = 0, gap_cnt = 0, cyc = 0;
    bit prev_maxing = 0, prev_run = 0, prev_gap = 0, was_busy = 0;
    bit finished = 0, in_gap;
    e = refModel();
    go = 1'b1;
    while (!finished && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      go = 1'b0;
      halt = 1'b0;
      mx_if.maxer_valid = 1'b0;
      if (busy) busy_n++;
      if (mx_if.maxing) begin
        maxing_n++;
        if (!prev_maxing) begin
          mx_cnt = 0;
          img_seen++;
          rises++;
        end else begin
          mx_cnt++;
        end
      end
      if (th_load) begin
        loads_n++;
        checkOutput({name, " th_out@load"}, 32'(th_out), thExp(thr_tab[img_seen]));
        checkOutput({name, " img_idx@load"}, 32'(img_idx), img_seen);
      end
      if (!mx_if.maxing) begin
        if (ips_next) inext_n++;
        if (ips_start) istart_n++;
      end
      if (run_en) begin
        run_n++;
        run_step = prev_run ? run_step + 1 : 0;
        if (!prev_run) checkOutput({name, " ips_start first run"}, 32'(ips_start), 1);
      end
      if (done) done_n++;
      in_gap  = busy && !mx_if.maxing && !th_load && !run_en && !done && !err;
      gap_cnt = in_gap ? (prev_gap ? gap_cnt + 1 : 0) : 0;
      finished = was_busy && !busy;
      was_busy = was_busy | busy;

      if (mx_if.maxing && mx_cnt == lat_tab[img_seen]) begin
        mx_if.maxer_valid = 1'b1;
        mx_if.threshold   = thr_tab[img_seen];
      end
      if (halt_phase == H_MAX && mx_if.maxing && img_seen == 0 && mx_cnt == halt_at) halt = 1'b1;
      if (halt_phase == H_RUN && run_en && run_step == halt_at) halt = 1'b1;
      if (halt_phase == H_GAP && in_gap && gap_cnt == halt_at) halt = 1'b1;
      if (noise && busy && $urandom_range(0, 9) == 0) go = 1'b1;
      if (noise && in_gap && $urandom_range(0, 3) == 0) begin
        mx_if.maxer_valid = 1'b1;
        mx_if.threshold   = 24'h000777;
      end
      mx_if.mx_start = 1'($urandom_range(0, 1));
      mx_if.mx_next  = 1'($urandom_range(0, 1));
      #1;
      if (mx_if.maxing) begin
        checkOutput({name, " ips_start passthru"}, 32'(ips_start), 32'(mx_if.mx_start));
        checkOutput({name, " ips_next passthru"}, 32'(ips_next), 32'(mx_if.mx_next));
      end
      prev_maxing = mx_if.maxing;
      prev_run    = run_en;
      prev_gap    = in_gap;
    end
    go = 1'b0;
    halt = 1'b0;
    mx_if.maxer_valid = 1'b0;
    if (e.loads > 0) th_model = thExp(thr_tab[e.loads - 1]);
    checkOutput({name, " finished in budget"}, 32'(finished), 1);
    checkOutput({name, " busy cycles"}, busy_n, e.busy);
    checkOutput({name, " maxing cycles"}, maxing_n, e.maxing);
    checkOutput({name, " maxing rises"}, rises, e.started);
    checkOutput({name, " th_load count"}, loads_n, e.loads);
    checkOutput({name, " run_en cycles"}, run_n, e.run);
    checkOutput({name, " ips_next cycles"}, inext_n, e.run);
    checkOutput({name, " ips_start count"}, istart_n, e.starts);
    checkOutput({name, " done count"}, done_n, e.done);
    checkOutput({name, " img_idx final"}, 32'(img_idx), e.started - 1);
    checkOutput({name, " th_out final"}, 32'(th_out), th_model);
    checkOutput({name, " err low"}, 32'(err), 0);
    if (!finished) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      th_model = 0;
    end
  endtask

  // Maxer never answers: expect the watchdog after MAX_TO cycles, then a
  // sticky error that ignores go until reset.
  task automatic watchdogTest();
    int mx_n = 0, cyc = 0, late_n = 0, busy_n = 0;
    go = 1'b1;
    mx_if.maxer_valid = 1'b0;
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      go = 1'b0;
      if (mx_if.maxing) mx_n++;
      if (err) break;
    end
    checkOutput("wd maxing cycles", mx_n, MAX_TO);
    checkOutput("wd err", 32'(err), 1);
    checkOutput("wd maxing off", 32'(mx_if.maxing), 0);
    for (int i = 0; i < 20; i++) begin
      go = 1'b1;
      @(posedge clk);
      #1;
      if (mx_if.maxing || !err) late_n++;
      if (busy) busy_n++;
    end
    go = 1'b0;
    checkOutput("wd go ignored", late_n, 0);
    checkOutput("wd busy held", busy_n, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    th_model = 0;
    checkOutput("wd err cleared", 32'(err), 0);
    checkOutput("wd busy cleared", 32'(busy), 0);
  endtask

  initial begin
    int idle_busy;
    rst = 1'b1;
    go = 1'b0;
    halt = 1'b0;
    mx_if.maxer_valid = 1'b0;
    mx_if.threshold   = '0;
    mx_if.mx_start    = 1'b0;
    mx_if.mx_next     = 1'b0;
    th_model = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset maxing", 32'(mx_if.maxing), 0);
    checkOutput("reset ips_start", 32'(ips_start), 0);
    checkOutput("reset ips_next", 32'(ips_next), 0);
    checkOutput("reset th_out", 32'(th_out), 0);
    checkOutput("reset th_load", 32'(th_load), 0);
    checkOutput("reset run_en", 32'(run_en), 0);
    checkOutput("reset img_idx", 32'(img_idx), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset err", 32'(err), 0);
    rst = 1'b0;

    $display("[TB] nominal batch");
    lat_tab = '{207, 207};
    thr_tab = '{24'h00A000, 24'h012345};
    halt_phase = H_NONE; halt_at = 0; noise = 0;
    applyStimulus("nominal");

    $display("[TB] zero threshold");
    lat_tab = '{int'($urandom_range(1, 250)), int'($urandom_range(1, 250))};
    thr_tab = '{24'h000000, 24'($urandom)};
    applyStimulus("zero_th");

    $display("[TB] halt in MAX");
    lat_tab = '{207, 100};
    thr_tab = '{24'h0BBBBB, 24'h0CCCCC};
    halt_phase = H_MAX; halt_at = 50;
    applyStimulus("halt_max");

    $display("[TB] halt in RUN");
    lat_tab = '{int'($urandom_range(1, 250)), 30};
    thr_tab = '{24'($urandom), 24'h000001};
    halt_phase = H_RUN; halt_at = 100;
    applyStimulus("halt_run");

    $display("[TB] halt in GAP");
    lat_tab = '{int'($urandom_range(1, 250)), 30};
    thr_tab = '{24'($urandom), 24'h000002};
    halt_phase = H_GAP; halt_at = int'($urandom_range(0, T_GAP - 1));
    applyStimulus("halt_gap");

    $display("[TB] go with halt in IDLE");
    idle_busy = 0;
    go = 1'b1;
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      go = 1'b0;
      halt = 1'b0;
      if (busy || mx_if.maxing) idle_busy++;
    end
    checkOutput("go_halt stays idle", idle_busy, 0);

    $display("[TB] randomized batches with noise");
    halt_phase = H_NONE; halt_at = 0; noise = 1;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) lat_tab = '{0, MAX_TO - 1};
      else lat_tab = '{int'($urandom_range(0, MAX_TO - 1)), int'($urandom_range(0, MAX_TO - 1))};
      for (int i = 0; i < NUM_IMG; i++)
        thr_tab[i] = ($urandom_range(0, 4) == 0) ? '0 : 24'($urandom);
      applyStimulus("random");
    end
    noise = 0;

    $display("[TB] watchdog");
    watchdogTest();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
